// File: rtl/keyboard_pkg.sv
// Shared types and constants for the keyboard direction queue: direction
// encoding, PS/2 scancodes for both players, and the reversal helper.
package keyboard_pkg;

    typedef enum logic [1:0] {
        UP    = 2'b00,
        RIGHT = 2'b01,
        DOWN  = 2'b10,
        LEFT  = 2'b11
    } dir_t;

    localparam logic [7:0] KEY_W = 8'h1D;
    localparam logic [7:0] KEY_D = 8'h23;
    localparam logic [7:0] KEY_S = 8'h1B;
    localparam logic [7:0] KEY_A = 8'h1C;
    localparam logic [7:0] KEY_I = 8'h43;
    localparam logic [7:0] KEY_L = 8'h4B;
    localparam logic [7:0] KEY_K = 8'h42;
    localparam logic [7:0] KEY_J = 8'h3B;

    // Opposite directions differ only in the upper encoding bit
    function automatic dir_t reverse_of(input dir_t d);
        return dir_t'(d ^ 2'b10);
    endfunction

endpackage

// File: rtl/keyboard_dir_queue_fifo.sv
// Per-player direction FIFO: power-of-two depth, 2-bit entries, exposes head,
// most recent entry (tail) and occupancy. A push into a full queue succeeds
// only when a pop happens in the same cycle.
module dir_fifo
    import keyboard_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          push,
    input  logic          pop,
    input  dir_t          din,
    output dir_t          head,
    output dir_t          tail,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    dir_t          mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic          push_ok_s;
    logic          pop_ok_s;

    // Status flags, handshake qualification and read ports
    always_comb begin
        full      = (count_r == CW'(DEPTH));
        empty     = (count_r == CW'(0));
        pop_ok_s  = pop & ~empty;
        push_ok_s = push & (~full | pop_ok_s);
        head      = mem_r[rd_ptr_r];
        tail      = mem_r[wr_ptr_r - AW'(1)];
        count     = count_r;
    end

    // Storage, pointers and occupancy; pointers wrap naturally at DEPTH
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= UP;
            end
            wr_ptr_r <= AW'(0);
            rd_ptr_r <= AW'(0);
            count_r  <= CW'(0);
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= din;
                wr_ptr_r        <= wr_ptr_r + AW'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/keyboard_dir_queue.sv
// Turns PS/2 make events into per-player direction queues, rejecting repeats
// and reversals, and advances each player's direction on every game tick.
module keyboard_dir_queue
    import keyboard_pkg::*;
#(
    parameter int         NUM_PLAYERS = 1,
    parameter int         DEPTH       = 4,
    parameter logic [1:0] INIT_DIR    = 2'b01,
    localparam int        CW          = $clog2(DEPTH + 1)
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          valid,
    input  logic                          makeBreak,
    input  logic [7:0]                    outCode,
    input  logic                          tick,
    output logic [2*NUM_PLAYERS-1:0]      dir_out,
    output logic [NUM_PLAYERS*CW-1:0]     pending,
    output logic [NUM_PLAYERS-1:0]        rev_rej,
    output logic [NUM_PLAYERS-1:0]        drop
);

    logic       valid_r;
    logic       valid_q_r;
    logic       make_r;
    logic [7:0] code_r;
    logic       armed_r;
    logic       event_s;

    // Input capture and edge detect; armed_r stays low until valid is seen
    // low after reset, so a level held through reset never fires
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_r   <= 1'b0;
            valid_q_r <= 1'b0;
            make_r    <= 1'b0;
            code_r    <= 8'h00;
            armed_r   <= 1'b0;
        end else begin
            valid_r   <= valid;
            valid_q_r <= valid_r;
            make_r    <= makeBreak;
            code_r    <= outCode;
            armed_r   <= armed_r | ~valid;
        end
    end

    assign event_s = valid_r & ~valid_q_r & make_r & armed_r;

    for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
        dir_t          key_dir_s;
        logic          key_hit_s;
        dir_t          ref_dir_s;
        dir_t          head_s;
        dir_t          tail_s;
        dir_t          dir_r;
        logic          full_s;
        logic          empty_s;
        logic          same_s;
        logic          rev_s;
        logic          push_s;
        logic          pop_s;
        logic          rev_rej_r;
        logic          drop_r;
        logic [CW-1:0] count_s;

        // Map this player's four keys; every other scancode is not ours
        always_comb begin
            key_hit_s = 1'b1;
            key_dir_s = UP;
            if (p == 0) begin
                case (code_r)
                    KEY_W:   key_dir_s = UP;
                    KEY_D:   key_dir_s = RIGHT;
                    KEY_S:   key_dir_s = DOWN;
                    KEY_A:   key_dir_s = LEFT;
                    default: key_hit_s = 1'b0;
                endcase
            end else begin
                case (code_r)
                    KEY_I:   key_dir_s = UP;
                    KEY_L:   key_dir_s = RIGHT;
                    KEY_K:   key_dir_s = DOWN;
                    KEY_J:   key_dir_s = LEFT;
                    default: key_hit_s = 1'b0;
                endcase
            end
        end

        // Compare against the last queued move so chained keys stay legal
        always_comb begin
            ref_dir_s = empty_s ? dir_r : tail_s;
            same_s    = (key_dir_s == ref_dir_s);
            rev_s     = (key_dir_s == reverse_of(ref_dir_s));
            push_s    = event_s & key_hit_s & ~same_s & ~rev_s;
            pop_s     = tick & ~empty_s;
        end

        dir_fifo #(.DEPTH(DEPTH)) u_fifo (
            .clk     (clk),
            .reset_n (reset_n),
            .push    (push_s),
            .pop     (pop_s),
            .din     (key_dir_s),
            .head    (head_s),
            .tail    (tail_s),
            .full    (full_s),
            .empty   (empty_s),
            .count   (count_s)
        );

        // Current direction and one-cycle reject pulses
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                dir_r     <= dir_t'(INIT_DIR);
                rev_rej_r <= 1'b0;
                drop_r    <= 1'b0;
            end else begin
                if (pop_s) begin
                    dir_r <= head_s;
                end else begin
                    dir_r <= dir_r;
                end
                rev_rej_r <= event_s & key_hit_s & rev_s;
                drop_r    <= push_s & full_s & ~pop_s;
            end
        end

        assign dir_out[2*p +: 2]   = dir_r;
        assign pending[p*CW +: CW] = count_s;
        assign rev_rej[p]          = rev_rej_r;
        assign drop[p]             = drop_r;
    end

endmodule

// File: tb/tb_keyboard_dir_queue.sv
// Two-player, depth-4 bench: a table of key/tick vectors with hand-derived
// expectations, a scoreboard of queued directions, and corner-case sequences.
module tb_keyboard_dir_queue;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       valid;
    logic       makeBreak;
    logic [7:0] outCode;
    logic       tick;
    logic [3:0] dir_out;
    logic [5:0] pending;
    logic [1:0] rev_rej;
    logic [1:0] drop;

    int checks = 0;
    int errors = 0;

    logic [1:0] sb0[$];
    logic [1:0] sb1[$];
    logic [1:0] mdir0;
    logic [1:0] mdir1;
    logic [2:0] prev0;
    logic [2:0] prev1;

    typedef struct {
        bit         is_tick;
        logic [7:0] code;
        logic       mk;
        logic [1:0] rev;
        logic [1:0] drp;
        logic [2:0] p0;
        logic [2:0] p1;
    } vec_t;

    vec_t vt[18];

    always #5 clk = ~clk;

    keyboard_dir_queue #(.NUM_PLAYERS(2), .DEPTH(4), .INIT_DIR(2'b01)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .valid     (valid),
        .makeBreak (makeBreak),
        .outCode   (outCode),
        .tick      (tick),
        .dir_out   (dir_out),
        .pending   (pending),
        .rev_rej   (rev_rej),
        .drop      (drop)
    );

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [1:0] tb_dir(input logic [7:0] c);
        case (c)
            8'h1D, 8'h43: return 2'b00;
            8'h23, 8'h4B: return 2'b01;
            8'h1B, 8'h42: return 2'b10;
            8'h1C, 8'h3B: return 2'b11;
            default:      return 2'b00;
        endcase
    endfunction

    // One-cycle valid pulse; optional tick lands on the queue-write edge.
    // Returns just after the edge where the effect becomes visible.
    task automatic press(input logic [7:0] code, input logic mk, input logic with_tick);
        @(negedge clk);
        valid = 1'b1; makeBreak = mk; outCode = code;
        @(negedge clk);
        valid = 1'b0; tick = with_tick;
        @(negedge clk);
        tick = 1'b0;
    endtask

    task automatic pulses_clear(input string name);
        @(negedge clk);
        check({name, "_rev_clr"}, 8'(rev_rej), 8'h00);
        check({name, "_drop_clr"}, 8'(drop), 8'h00);
    endtask

    task automatic do_tick(input string name);
        @(negedge clk);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        if (sb0.size() > 0) mdir0 = sb0.pop_front();
        if (sb1.size() > 0) mdir1 = sb1.pop_front();
        check({name, "_dir0"}, 8'(dir_out[1:0]), 8'(mdir0));
        check({name, "_dir1"}, 8'(dir_out[3:2]), 8'(mdir1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        vt[0]  = '{1'b0, 8'h1D, 1'b1, 2'b00, 2'b00, 3'd1, 3'd0};
        vt[1]  = '{1'b0, 8'h1B, 1'b1, 2'b01, 2'b00, 3'd1, 3'd0};
        vt[2]  = '{1'b1, 8'h00, 1'b0, 2'b00, 2'b00, 3'd0, 3'd0};
        vt[3]  = '{1'b0, 8'h1D, 1'b1, 2'b00, 2'b00, 3'd0, 3'd0};
        vt[4]  = '{1'b0, 8'h1C, 1'b0, 2'b00, 2'b00, 3'd0, 3'd0};
        vt[5]  = '{1'b0, 8'h29, 1'b1, 2'b00, 2'b00, 3'd0, 3'd0};
        vt[6]  = '{1'b0, 8'h1C, 1'b1, 2'b00, 2'b00, 3'd1, 3'd0};
        vt[7]  = '{1'b0, 8'h1B, 1'b1, 2'b00, 2'b00, 3'd2, 3'd0};
        vt[8]  = '{1'b0, 8'h23, 1'b1, 2'b00, 2'b00, 3'd3, 3'd0};
        vt[9]  = '{1'b0, 8'h1D, 1'b1, 2'b00, 2'b00, 3'd4, 3'd0};
        vt[10] = '{1'b0, 8'h1C, 1'b1, 2'b00, 2'b01, 3'd4, 3'd0};
        vt[11] = '{1'b0, 8'h43, 1'b1, 2'b00, 2'b00, 3'd4, 3'd1};
        vt[12] = '{1'b0, 8'h3B, 1'b1, 2'b00, 2'b00, 3'd4, 3'd2};
        vt[13] = '{1'b0, 8'h4B, 1'b1, 2'b10, 2'b00, 3'd4, 3'd2};
        vt[14] = '{1'b1, 8'h00, 1'b0, 2'b00, 2'b00, 3'd3, 3'd1};
        vt[15] = '{1'b1, 8'h00, 1'b0, 2'b00, 2'b00, 3'd2, 3'd0};
        vt[16] = '{1'b1, 8'h00, 1'b0, 2'b00, 2'b00, 3'd1, 3'd0};
        vt[17] = '{1'b1, 8'h00, 1'b0, 2'b00, 2'b00, 3'd0, 3'd0};

        reset_n = 1'b0; valid = 1'b0; makeBreak = 1'b0; outCode = 8'h00; tick = 1'b0;
        mdir0 = 2'b01; mdir1 = 2'b01; prev0 = 3'd0; prev1 = 3'd0;
        repeat (3) @(negedge clk);
        check("rst_dir", 8'(dir_out), 8'h05);
        check("rst_pending", 8'(pending), 8'h00);
        check("rst_rev", 8'(rev_rej), 8'h00);
        check("rst_drop", 8'(drop), 8'h00);
        reset_n = 1'b1;
        @(negedge clk);

        // Tick on empty queues holds the reset direction
        do_tick("idle_tick");
        check("idle_pending", 8'(pending), 8'h00);
        check("idle_pulses", 8'({rev_rej, drop}), 8'h00);

        for (int i = 0; i < 18; i++) begin
            if (vt[i].is_tick) begin
                do_tick($sformatf("v%0d_tick", i));
            end else begin
                press(vt[i].code, vt[i].mk, 1'b0);
                if (vt[i].p0 > prev0) sb0.push_back(tb_dir(vt[i].code));
                if (vt[i].p1 > prev1) sb1.push_back(tb_dir(vt[i].code));
                check($sformatf("v%0d_rev", i), 8'(rev_rej), 8'(vt[i].rev));
                check($sformatf("v%0d_drop", i), 8'(drop), 8'(vt[i].drp));
                pulses_clear($sformatf("v%0d", i));
            end
            check($sformatf("v%0d_pend0", i), 8'(pending[2:0]), 8'(vt[i].p0));
            check($sformatf("v%0d_pend1", i), 8'(pending[5:3]), 8'(vt[i].p1));
            prev0 = vt[i].p0;
            prev1 = vt[i].p1;
        end

        // Held valid: one enqueue only; repeat of the tail is silently dropped
        @(negedge clk);
        valid = 1'b1; makeBreak = 1'b1; outCode = 8'h23;
        repeat (10) @(negedge clk);
        valid = 1'b0;
        check("held_pend0", 8'(pending[2:0]), 8'h01);
        check("held_pend1", 8'(pending[5:3]), 8'h00);
        sb0.push_back(2'b01);
        @(negedge clk);
        press(8'h23, 1'b1, 1'b0);
        check("repeat_pend0", 8'(pending[2:0]), 8'h01);
        check("repeat_pulses", 8'({rev_rej, drop}), 8'h00);
        do_tick("held_tick");
        check("held_tick_pend0", 8'(pending[2:0]), 8'h00);

        // Fill player 0, then a new key coincident with a tick on the full queue
        press(8'h1D, 1'b1, 1'b0); sb0.push_back(2'b00);
        press(8'h1C, 1'b1, 1'b0); sb0.push_back(2'b11);
        press(8'h1B, 1'b1, 1'b0); sb0.push_back(2'b10);
        press(8'h23, 1'b1, 1'b0); sb0.push_back(2'b01);
        check("fill_pend0", 8'(pending[2:0]), 8'h04);
        press(8'h1D, 1'b1, 1'b1);
        mdir0 = sb0.pop_front();
        sb0.push_back(2'b00);
        check("full_tick_drop", 8'(drop), 8'h00);
        check("full_tick_pend0", 8'(pending[2:0]), 8'h04);
        check("full_tick_dir0", 8'(dir_out[1:0]), 8'(mdir0));
        check("full_tick_dir1", 8'(dir_out[3:2]), 8'(mdir1));

        // Player 1 empty: tick and enqueue together, direction must not bypass
        press(8'h42, 1'b1, 1'b1);
        mdir0 = sb0.pop_front();
        sb1.push_back(2'b10);
        check("empty_tick_dir0", 8'(dir_out[1:0]), 8'(mdir0));
        check("empty_tick_dir1", 8'(dir_out[3:2]), 8'(mdir1));
        check("empty_tick_pend0", 8'(pending[2:0]), 8'h03);
        check("empty_tick_pend1", 8'(pending[5:3]), 8'h01);
        check("empty_tick_rev", 8'(rev_rej), 8'h00);
        do_tick("after_tick");
        check("after_pend0", 8'(pending[2:0]), 8'h02);
        check("after_pend1", 8'(pending[5:3]), 8'h00);

        // Reset mid-event: immediate flush, and a level held through reset is ignored
        @(negedge clk);
        valid = 1'b1; makeBreak = 1'b1; outCode = 8'h1C;
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("midrst_pending", 8'(pending), 8'h00);
        check("midrst_dir", 8'(dir_out), 8'h05);
        check("midrst_pulses", 8'({rev_rej, drop}), 8'h00);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        check("held_thru_rst_pend", 8'(pending), 8'h00);
        valid = 1'b0;
        sb0.delete(); sb1.delete();
        mdir0 = 2'b01; mdir1 = 2'b01;
        @(negedge clk);
        press(8'h1D, 1'b1, 1'b0);
        sb0.push_back(2'b00);
        check("fresh_edge_pend", 8'(pending), 8'h01);
        do_tick("post_rst_tick");
        check("post_rst_pend", 8'(pending), 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/keyboard_dir_queue.md
KEYBOARD_DIR_QUEUE -- requirements
Module: keyboard_dir_queue

Interface
REQ-001 Parameter NUM_PLAYERS, default 1, number of independent direction channels (1 or 2).
REQ-002 Parameter DEPTH, default 4, per-player direction queue depth (power of two, 2..16).
REQ-003 Parameter INIT_DIR, default 2'b01, direction loaded on reset (right).
REQ-004 clk  input  1  system clock, all state on rising edge.
REQ-005 reset_n  input  1  asynchronous active-low reset.
REQ-006 valid  input  1  scancode-valid level from keyboard_press_driver.
REQ-007 makeBreak  input  1  1 = key press (make), 0 = release (break).
REQ-008 outCode  input  8  PS/2 scancode.
REQ-009 tick  input  1  game-step strobe, one cycle wide; consumes one queued direction per player.
REQ-010 dir_out  output  2*NUM_PLAYERS  current direction per player, player p at bits [2p+1:2p].
REQ-011 pending  output  NUM_PLAYERS*$clog2(DEPTH+1)  per-player queue occupancy.
REQ-012 rev_rej  output  NUM_PLAYERS  one-cycle pulse, key rejected as reversal.
REQ-013 drop  output  NUM_PLAYERS  one-cycle pulse, key rejected because queue full.

Function
REQ-014 Direction encoding SHALL be up=00, right=01, down=10, left=11; d2 is reverse of d1 iff d2 == d1 ^ 2'b10.
REQ-015 Player 0 keys SHALL be W=8'h1D up, D=8'h23 right, S=8'h1B down, A=8'h1C left.
REQ-016 Player 1 keys (NUM_PLAYERS=2 only) SHALL be I=8'h43 up, L=8'h4B right, K=8'h42 down, J=8'h3B left.
REQ-017 A key event SHALL be accepted only on the cycle after a 0->1 transition of registered valid with makeBreak=1; held valid SHALL NOT generate repeats.
REQ-018 Break events and unmapped scancodes SHALL be ignored with no output change.
REQ-019 Reference direction for a player SHALL be the tail entry if the queue is non-empty, else dir_out.
REQ-020 Accepted key equal to the reference direction SHALL be discarded silently.
REQ-021 Accepted key that is the reverse of the reference direction SHALL be discarded and pulse rev_rej[p] for exactly one cycle.
REQ-022 Otherwise, if pending[p] < DEPTH, the key SHALL be enqueued; if full, it SHALL be discarded and pulse drop[p] for one cycle.
REQ-023 On tick with pending[p] > 0, dir_out[p] SHALL take the head entry in the next cycle and pending[p] SHALL decrement; with pending[p]==0, dir_out[p] SHALL hold.
REQ-024 Simultaneous tick and enqueue on a full queue SHALL pop and push in the same cycle with no drop; pending stays DEPTH.
REQ-025 Simultaneous tick and enqueue on an empty queue SHALL compare against the pre-tick dir_out, enqueue, and leave dir_out unchanged (no bypass).
REQ-026 Latency from the first valid-high cycle to a queue write SHALL be 2 cycles; from tick to dir_out update, 1 cycle.
REQ-027 Queue pointers SHALL wrap modulo DEPTH; pending SHALL never exceed DEPTH or underflow.
REQ-028 Players SHALL operate independently; a key for one player SHALL never affect another.

Reset
REQ-029 While reset_n=0: every dir_out slice = INIT_DIR, pending = 0, rev_rej = 0, drop = 0, edge-detect register = 0, queue pointers = 0.
REQ-030 Reset asserted mid-operation SHALL flush all queued entries immediately; no event in progress SHALL complete after release.
REQ-031 First accepted key after reset release SHALL require a fresh 0->1 valid edge.

Structure
REQ-032 Package keyboard_pkg SHALL hold the dir_t enum (UP, RIGHT, DOWN, LEFT), the eight scancode constants, and a reverse-of function.
REQ-033 Per-player queue SHALL be a sub-module dir_fifo (parameter DEPTH, 2-bit entries, push/pop/full/empty/count/tail), instantiated NUM_PLAYERS times in a generate loop.
REQ-034 The key decoder and reverse check SHALL be combinational in the top level; all outputs SHALL be registered.

Verification
REQ-035 Reset, then tick -> dir_out=01, pending=0, no pulses.
REQ-036 P0 press W (1D), then S (1B), DEPTH=4 -> W queued (pending=1); S rejected, rev_rej[0] pulses once; tick -> dir_out=00.
REQ-037 P0 press W, A, S, D, W with no tick -> pending=4 after fourth key, fifth pulses drop[0]; four ticks -> dir_out 00,11,10,01.
REQ-038 valid held high 10 cycles with 1D -> exactly one enqueue; repeat 1D after release -> discarded, no pulse.
REQ-039 NUM_PLAYERS=2: press I (43) then J (3B) -> only player 1 queue fills; dir_out[1:0] stays 01 through ticks.
REQ-040 Full queue, tick coincident with new key -> no drop, pending stays 4; reset_n low mid-sequence -> pending=0, dir_out=01 within same cycle.
